uart_transmitter_controller: RTL and testbench
==============================================

// Module: UART_transmitter_controller
// PURPOSE
//   System-controller return path. Captures register-file read data and ALU
//   results, splits them into bytes and pushes them into the TX async FIFO
//   feeding the UART transmitter. Pairs with UART_receiver_controller, which
//   issues the read/ALU commands. Runs in the reference clock domain.
// PARAMETERS
//   DATA_WIDTH        8   UART frame / register-file data width (bits)
//   ALU_RESULT_WIDTH  16  ALU result width; must equal 2*DATA_WIDTH
// PORTS
//   clk               in   1                reference clock, rising edge
//   reset             in   1                synchronous, active-high
//   enable            in   1                1 = accept new results
//   read_data         in   DATA_WIDTH       register-file read data
//   read_data_valid   in   1                1-cycle strobe, read_data valid
//   ALU_result        in   ALU_RESULT_WIDTH ALU result
//   ALU_result_valid  in   1                1-cycle strobe, ALU_result valid
//   FIFO_full         in   1                TX FIFO cannot accept a write
//   FIFO_write_data   out  DATA_WIDTH       byte to TX FIFO
//   FIFO_write_enable out  1                push FIFO_write_data this cycle
//   busy              out  1                1 = transfer in progress
// BEHAVIOUR
// - All state changes on the rising clk edge.
// - Reset (reset=1 at an edge): state=IDLE, holding regs=0, pending flags=0,
//   FIFO_write_enable=0, FIFO_write_data=0, busy=0. Reset mid-transfer
//   aborts it; unsent bytes are discarded.
// - FSM states: IDLE, SEND_READ, SEND_ALU_LOW, SEND_ALU_HIGH.
// - IDLE, enable=1:
//   - read_data_valid -> latch read_data, goto SEND_READ.
//   - ALU_result_valid -> latch ALU_result, goto SEND_ALU_LOW.
//   - Both valid in the same cycle -> latch both, set alu_pending, goto
//     SEND_READ.
// - IDLE, enable=0: strobes ignored, nothing latched.
// - Strobes arriving when state != IDLE are dropped; the in-flight transfer is
//   unaffected.
// - FIFO_write_enable = (state != IDLE) && !FIFO_full (combinational).
//   FIFO_write_data = byte for the current state:
//   - SEND_READ: held read byte.
//   - SEND_ALU_LOW: ALU[DATA_WIDTH-1:0].
//   - SEND_ALU_HIGH: ALU[2*DATA_WIDTH-1:DATA_WIDTH].
//   In IDLE it holds its last value.
// - A send state advances only on an edge where FIFO_write_enable=1:
//   - SEND_READ -> SEND_ALU_LOW if alu_pending (flag cleared), else IDLE.
//   - SEND_ALU_LOW -> SEND_ALU_HIGH.
//   - SEND_ALU_HIGH -> IDLE.
// - FIFO_full=1 stalls in the current state, holding data stable; there is
//   no timeout.
// - Latency: strobe sampled at edge N -> first FIFO_write_enable in cycle
//   N..N+1 (if not full). ALU result occupies 2 consecutive write cycles,
//   LSB byte first.
// - busy = (state != IDLE), registered with the state.
// - enable going low mid-transfer does not abort; it only blocks new captures
//   once back in IDLE.
// - Byte order and count per result are fixed; no framing/header bytes added.
// TESTING
// 1 read_data=0xA5 strobe, FIFO_full=0 -> one write of 0xA5 the next cycle,
//   busy high 1 cycle, then IDLE.
// 2 ALU_result=0x1234 strobe -> writes 0x34 then 0x12 on consecutive cycles;
//   exactly 2 FIFO_write_enable pulses.
// 3 ALU_result=0xBEEF, FIFO_full=1 for 5 cycles after the first write ->
//   0xEF written, 0xBE held stable with no write for 5 cycles, then written
//   once.
// 4 read_data=0x3C and ALU_result=0x0F0E strobed together -> writes 0x3C,
//   0x0E, 0x0F in order.
// 5 enable=0 with read strobe 0x77; and a read strobe 0x55 during an active
//   ALU transfer -> neither byte ever written.
// 6 reset asserted while in SEND_ALU_HIGH -> next cycle IDLE, busy=0, no
//   further writes; a new strobe afterwards works normally.

Source files
------------

// File: rtl/uart_transmitter_controller.sv
// UART transmitter controller: return path from register file / ALU into
// the TX async FIFO, one byte per write, ALU results sent LSB first.
module uart_transmitter_controller #(
   parameter int DATA_WIDTH       = 8,
   parameter int ALU_RESULT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [DATA_WIDTH-1:0]       read_data,
   input  logic                        read_data_valid,
   input  logic [ALU_RESULT_WIDTH-1:0] ALU_result,
   input  logic                        ALU_result_valid,
   input  logic                        FIFO_full,
   output logic [DATA_WIDTH-1:0]       FIFO_write_data,
   output logic                        FIFO_write_enable,
   output logic                        busy
);

   typedef enum logic [1:0] {
      IDLE,
      SEND_READ,
      SEND_ALU_LOW,
      SEND_ALU_HIGH
   } state_t;

   state_t state;
   state_t next_state;

   logic [DATA_WIDTH-1:0]       read_hold;
   logic [ALU_RESULT_WIDTH-1:0] alu_hold;
   logic [DATA_WIDTH-1:0]       last_byte;
   logic [DATA_WIDTH-1:0]       cur_byte;
   logic                        alu_pending;
   logic                        capture_read;
   logic                        capture_alu;
   logic                        advance;

   assign capture_read = (state == IDLE) && enable && read_data_valid;
   assign capture_alu  = (state == IDLE) && enable && ALU_result_valid;
   assign advance      = FIFO_write_enable;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (capture_read)
               next_state = SEND_READ;
            else if (capture_alu)
               next_state = SEND_ALU_LOW;
         end
         SEND_READ: begin
            if (advance)
               next_state = alu_pending ? SEND_ALU_LOW : IDLE;
         end
         SEND_ALU_LOW: begin
            if (advance)
               next_state = SEND_ALU_HIGH;
         end
         SEND_ALU_HIGH: begin
            if (advance)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic; IDLE replays the last byte so the data bus stays quiet
   always_comb begin
      cur_byte = last_byte;
      unique case (state)
         IDLE:          cur_byte = last_byte;
         SEND_READ:     cur_byte = read_hold;
         SEND_ALU_LOW:  cur_byte = alu_hold[DATA_WIDTH-1:0];
         SEND_ALU_HIGH: cur_byte = alu_hold[2*DATA_WIDTH-1:DATA_WIDTH];
         default:       cur_byte = last_byte;
      endcase
      FIFO_write_data   = cur_byte;
      FIFO_write_enable = (state != IDLE) && !FIFO_full;
   end

   // Holding registers and pending flag
   always_ff @(posedge clk) begin
      if (reset) begin
         read_hold   <= '0;
         alu_hold    <= '0;
         last_byte   <= '0;
         alu_pending <= 1'b0;
      end else begin
         if (capture_read)
            read_hold <= read_data;
         if (capture_alu)
            alu_hold <= ALU_result;
         if (state != IDLE)
            last_byte <= cur_byte;
         if (capture_read && capture_alu)
            alu_pending <= 1'b1;
         else if (state == SEND_READ && advance)
            alu_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_transmitter_controller.sv
// Directed bench for uart_transmitter_controller: byte order, stalls,
// dropped strobes and mid-transfer reset.
module tb_uart_transmitter_controller;

   logic        reference_clk_tb;
   logic        reset;
   logic        enable;
   logic [7:0]  read_data;
   logic        read_data_valid;
   logic [15:0] ALU_result;
   logic        ALU_result_valid;
   logic        FIFO_full;
   logic [7:0]  FIFO_write_data;
   logic        FIFO_write_enable;
   logic        busy;

   int checks;
   int failures;
   logic [7:0] wr_log[$];
   logic [9:0] obs;

   uart_transmitter_controller #(
      .DATA_WIDTH(8),
      .ALU_RESULT_WIDTH(16)
   ) dut (
      .clk               (reference_clk_tb),
      .reset             (reset),
      .enable            (enable),
      .read_data         (read_data),
      .read_data_valid   (read_data_valid),
      .ALU_result        (ALU_result),
      .ALU_result_valid  (ALU_result_valid),
      .FIFO_full         (FIFO_full),
      .FIFO_write_data   (FIFO_write_data),
      .FIFO_write_enable (FIFO_write_enable),
      .busy              (busy)
   );

   initial reference_clk_tb = 1'b0;
   always #5 reference_clk_tb = ~reference_clk_tb;

   // Record every byte the FIFO would accept
   always @(negedge reference_clk_tb)
      if (!reset && FIFO_write_enable)
         wr_log.push_back(FIFO_write_data);

   assign obs = {busy, FIFO_write_enable, FIFO_write_data};

   task automatic tick();
      @(posedge reference_clk_tb);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (obs !== 10'h000) begin
         failures++;
         $display("FAIL reset obs=%h exp=%h", obs, 10'h000);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (obs !== 10'h000) begin
         failures++;
         $display("FAIL reset_idle obs=%h exp=%h", obs, 10'h000);
      end
   endtask

   task automatic test_read();
      wr_log.delete();
      read_data = 8'hA5;
      read_data_valid = 1'b1;
      tick();
      checks++;
      if (obs !== {2'b11, 8'hA5}) begin
         failures++;
         $display("FAIL read_send obs=%h exp=%h", obs, {2'b11, 8'hA5});
      end
      read_data_valid = 1'b0;
      tick();
      checks++;
      if (obs !== {2'b00, 8'hA5}) begin
         failures++;
         $display("FAIL read_idle obs=%h exp=%h", obs, {2'b00, 8'hA5});
      end
      tick();
      tick();
      checks++;
      if (wr_log.size() != 1 || wr_log[0] !== 8'hA5) begin
         failures++;
         $display("FAIL read_log size=%0d first=%h exp size=1 first=a5",
                  wr_log.size(), wr_log[0]);
      end
   endtask

   task automatic test_alu();
      wr_log.delete();
      ALU_result = 16'h1234;
      ALU_result_valid = 1'b1;
      tick();
      ALU_result_valid = 1'b0;
      checks++;
      if (obs !== {2'b11, 8'h34}) begin
         failures++;
         $display("FAIL alu_low obs=%h exp=%h", obs, {2'b11, 8'h34});
      end
      tick();
      checks++;
      if (obs !== {2'b11, 8'h12}) begin
         failures++;
         $display("FAIL alu_high obs=%h exp=%h", obs, {2'b11, 8'h12});
      end
      tick();
      checks++;
      if (obs !== {2'b00, 8'h12}) begin
         failures++;
         $display("FAIL alu_idle obs=%h exp=%h", obs, {2'b00, 8'h12});
      end
      tick();
      checks++;
      if (wr_log.size() != 2 || wr_log[0] !== 8'h34
          || wr_log[1] !== 8'h12) begin
         failures++;
         $display("FAIL alu_log size=%0d b0=%h b1=%h exp 2 34 12",
                  wr_log.size(), wr_log[0], wr_log[1]);
      end
   endtask

   task automatic test_fifo_full();
      wr_log.delete();
      ALU_result = 16'hBEEF;
      ALU_result_valid = 1'b1;
      tick();
      ALU_result_valid = 1'b0;
      checks++;
      if (obs !== {2'b11, 8'hEF}) begin
         failures++;
         $display("FAIL full_low obs=%h exp=%h", obs, {2'b11, 8'hEF});
      end
      tick();
      FIFO_full = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs !== {2'b10, 8'hBE}) begin
            failures++;
            $display("FAIL full_stall%0d obs=%h exp=%h", i, obs,
                     {2'b10, 8'hBE});
         end
         if (i < 4)
            tick();
      end
      FIFO_full = 1'b0;
      #1;
      checks++;
      if (obs !== {2'b11, 8'hBE}) begin
         failures++;
         $display("FAIL full_release obs=%h exp=%h", obs, {2'b11, 8'hBE});
      end
      tick();
      checks++;
      if (obs !== {2'b00, 8'hBE}) begin
         failures++;
         $display("FAIL full_idle obs=%h exp=%h", obs, {2'b00, 8'hBE});
      end
      tick();
      checks++;
      if (wr_log.size() != 2 || wr_log[0] !== 8'hEF
          || wr_log[1] !== 8'hBE) begin
         failures++;
         $display("FAIL full_log size=%0d b0=%h b1=%h exp 2 ef be",
                  wr_log.size(), wr_log[0], wr_log[1]);
      end
   endtask

   task automatic test_both();
      wr_log.delete();
      read_data = 8'h3C;
      ALU_result = 16'h0F0E;
      read_data_valid = 1'b1;
      ALU_result_valid = 1'b1;
      tick();
      read_data_valid = 1'b0;
      ALU_result_valid = 1'b0;
      checks++;
      if (obs !== {2'b11, 8'h3C}) begin
         failures++;
         $display("FAIL both_read obs=%h exp=%h", obs, {2'b11, 8'h3C});
      end
      tick();
      checks++;
      if (obs !== {2'b11, 8'h0E}) begin
         failures++;
         $display("FAIL both_low obs=%h exp=%h", obs, {2'b11, 8'h0E});
      end
      tick();
      checks++;
      if (obs !== {2'b11, 8'h0F}) begin
         failures++;
         $display("FAIL both_high obs=%h exp=%h", obs, {2'b11, 8'h0F});
      end
      tick();
      checks++;
      if (obs !== {2'b00, 8'h0F}) begin
         failures++;
         $display("FAIL both_idle obs=%h exp=%h", obs, {2'b00, 8'h0F});
      end
      tick();
      checks++;
      if (wr_log.size() != 3 || wr_log[0] !== 8'h3C
          || wr_log[1] !== 8'h0E || wr_log[2] !== 8'h0F) begin
         failures++;
         $display("FAIL both_log size=%0d b0=%h b1=%h b2=%h exp 3 3c 0e 0f",
                  wr_log.size(), wr_log[0], wr_log[1], wr_log[2]);
      end
   endtask

   task automatic test_dropped();
      wr_log.delete();
      enable = 1'b0;
      read_data = 8'h77;
      read_data_valid = 1'b1;
      tick();
      read_data_valid = 1'b0;
      checks++;
      if (obs !== {2'b00, 8'h0F}) begin
         failures++;
         $display("FAIL disabled obs=%h exp=%h", obs, {2'b00, 8'h0F});
      end
      enable = 1'b1;
      ALU_result = 16'hA1B2;
      ALU_result_valid = 1'b1;
      tick();
      ALU_result_valid = 1'b0;
      enable = 1'b0;
      read_data = 8'h55;
      read_data_valid = 1'b1;
      checks++;
      if (obs !== {2'b11, 8'hB2}) begin
         failures++;
         $display("FAIL drop_low obs=%h exp=%h", obs, {2'b11, 8'hB2});
      end
      tick();
      read_data_valid = 1'b0;
      checks++;
      if (obs !== {2'b11, 8'hA1}) begin
         failures++;
         $display("FAIL drop_high obs=%h exp=%h", obs, {2'b11, 8'hA1});
      end
      tick();
      enable = 1'b1;
      tick();
      tick();
      checks++;
      if (wr_log.size() != 2 || wr_log[0] !== 8'hB2
          || wr_log[1] !== 8'hA1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL drop_log size=%0d b0=%h b1=%h busy=%b exp 2 b2 a1 0",
                  wr_log.size(), wr_log[0], wr_log[1], busy);
      end
   endtask

   task automatic test_reset_mid();
      wr_log.delete();
      ALU_result = 16'hC0DE;
      ALU_result_valid = 1'b1;
      tick();
      ALU_result_valid = 1'b0;
      checks++;
      if (obs !== {2'b11, 8'hDE}) begin
         failures++;
         $display("FAIL rst_low obs=%h exp=%h", obs, {2'b11, 8'hDE});
      end
      tick();
      FIFO_full = 1'b1;
      #1;
      checks++;
      if (obs !== {2'b10, 8'hC0}) begin
         failures++;
         $display("FAIL rst_high obs=%h exp=%h", obs, {2'b10, 8'hC0});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      FIFO_full = 1'b0;
      #1;
      checks++;
      if (obs !== 10'h000) begin
         failures++;
         $display("FAIL rst_abort obs=%h exp=%h", obs, 10'h000);
      end
      tick();
      tick();
      tick();
      checks++;
      if (wr_log.size() != 1 || wr_log[0] !== 8'hDE || obs !== 10'h000) begin
         failures++;
         $display("FAIL rst_log size=%0d b0=%h obs=%h exp 1 de 000",
                  wr_log.size(), wr_log[0], obs);
      end
      wr_log.delete();
      read_data = 8'h42;
      read_data_valid = 1'b1;
      tick();
      read_data_valid = 1'b0;
      checks++;
      if (obs !== {2'b11, 8'h42}) begin
         failures++;
         $display("FAIL rst_resume obs=%h exp=%h", obs, {2'b11, 8'h42});
      end
      tick();
      tick();
      checks++;
      if (wr_log.size() != 1 || wr_log[0] !== 8'h42 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_resume_log size=%0d b0=%h busy=%b exp 1 42 0",
                  wr_log.size(), wr_log[0], busy);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      enable = 1'b1;
      read_data = '0;
      read_data_valid = 1'b0;
      ALU_result = '0;
      ALU_result_valid = 1'b0;
      FIFO_full = 1'b0;
      test_reset();
      test_read();
      test_alu();
      test_fifo_full();
      test_both();
      test_dropped();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
